// File: rtl/ib_lut_bank_rd_sched.sv
// ============================================================================
// Module  : ib_lut_bank_rd_sched
// Brief   : Schedules four port reads onto two dual-port LUT banks and returns
//           all four LUT outputs as one response. Optional macro
//           IB_RD_ADDR_MERGE_EN lets identical {bank,page} requests share a
//           RAM port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ib_lut_bank_rd_sched #(
  parameter int ADDR_BW = 3,
  parameter int DATA_BW = 3
) (
  input  logic               i_sys_clk,
  input  logic               i_rstn,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [ADDR_BW-1:0] i_page_addr_a,
  input  logic [ADDR_BW-1:0] i_page_addr_b,
  input  logic [ADDR_BW-1:0] i_page_addr_c,
  input  logic [ADDR_BW-1:0] i_page_addr_d,
  input  logic               i_bank_addr_a,
  input  logic               i_bank_addr_b,
  input  logic               i_bank_addr_c,
  input  logic               i_bank_addr_d,
  output logic               o_bank0_en_p0,
  output logic               o_bank0_en_p1,
  output logic               o_bank1_en_p0,
  output logic               o_bank1_en_p1,
  output logic [ADDR_BW-1:0] o_bank0_addr_p0,
  output logic [ADDR_BW-1:0] o_bank0_addr_p1,
  output logic [ADDR_BW-1:0] o_bank1_addr_p0,
  output logic [ADDR_BW-1:0] o_bank1_addr_p1,
  input  logic [DATA_BW-1:0] i_bank0_dout_p0,
  input  logic [DATA_BW-1:0] i_bank0_dout_p1,
  input  logic [DATA_BW-1:0] i_bank1_dout_p0,
  input  logic [DATA_BW-1:0] i_bank1_dout_p1,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [DATA_BW-1:0] o_rsp_data_a,
  output logic [DATA_BW-1:0] o_rsp_data_b,
  output logic [DATA_BW-1:0] o_rsp_data_c,
  output logic [DATA_BW-1:0] o_rsp_data_d
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RSP   = 2'd3
  } t_state;

  t_state                          r_state;
  logic                            r_req_ready;
  logic                            r_rsp_valid;
  logic [3:0]                      r_pending;
  logic [3:0][ADDR_BW-1:0]         r_page;
  logic [3:0]                      r_bank;
  logic [3:0]                      r_gv;
  logic [3:0]                      r_gp;
  logic [3:0][DATA_BW-1:0]         r_rsp;

  logic [3:0]                      w_gnt;
  logic [3:0]                      w_gport;
  logic [1:0][1:0]                 w_en;
  logic [1:0][1:0][ADDR_BW-1:0]    w_addr;
  logic [1:0][1:0][DATA_BW-1:0]    w_dout;
  logic [3:0]                      w_left;

  assign w_dout[0][0] = i_bank0_dout_p0;
  assign w_dout[0][1] = i_bank0_dout_p1;
  assign w_dout[1][0] = i_bank1_dout_p0;
  assign w_dout[1][1] = i_bank1_dout_p1;

  // Per bank, walk ports in priority order A..D and hand out up to two RAM ports.
  always_comb begin
    logic [1:0] v_cnt;
    logic       v_merged;
    w_gnt    = '0;
    w_gport  = '0;
    w_en     = '0;
    w_addr   = '0;
    v_cnt    = '0;
    v_merged = 1'b0;
    if (r_state == S_ISSUE) begin
      for (int b = 0; b < 2; b++) begin
        v_cnt = '0;
        for (int i = 0; i < 4; i++) begin
          if (r_pending[i] && (r_bank[i] == b[0])) begin
            v_merged = 1'b0;
`ifdef IB_RD_ADDR_MERGE_EN
            for (int j = 0; j < i; j++) begin
              if (!v_merged && w_gnt[j] && (r_bank[j] == r_bank[i]) &&
                  (r_page[j] == r_page[i])) begin
                v_merged   = 1'b1;
                w_gnt[i]   = 1'b1;
                w_gport[i] = w_gport[j];
              end
            end
`endif
            if (!v_merged && (v_cnt < 2'd2)) begin
              w_gnt[i]               = 1'b1;
              w_gport[i]             = v_cnt[0];
              w_en[b][v_cnt[0]]      = 1'b1;
              w_addr[b][v_cnt[0]]    = r_page[i];
              v_cnt                  = v_cnt + 2'd1;
            end
          end
        end
      end
    end
  end

  assign w_left = r_pending & ~w_gnt;

  always_ff @(posedge i_sys_clk) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_pending   <= '0;
      r_page      <= '0;
      r_bank      <= '0;
      r_gv        <= '0;
      r_gp        <= '0;
      r_rsp       <= '0;
    end else begin
      // Data returns one cycle after the grant; capture overlaps the next issue.
      for (int i = 0; i < 4; i++) begin
        if (r_gv[i]) r_rsp[i] <= w_dout[r_bank[i]][r_gp[i]];
      end
      case (r_state)
        S_IDLE: begin
          r_gv <= '0;
          if (i_req_valid) begin
            r_page      <= {i_page_addr_d, i_page_addr_c, i_page_addr_b, i_page_addr_a};
            r_bank      <= {i_bank_addr_d, i_bank_addr_c, i_bank_addr_b, i_bank_addr_a};
            r_pending   <= 4'b1111;
            r_req_ready <= 1'b0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_gv      <= w_gnt;
          r_gp      <= w_gport;
          r_pending <= w_left;
          if (w_left == 4'b0000) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_gv        <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready     = r_req_ready;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_data_a    = r_rsp[0];
  assign o_rsp_data_b    = r_rsp[1];
  assign o_rsp_data_c    = r_rsp[2];
  assign o_rsp_data_d    = r_rsp[3];
  assign o_bank0_en_p0   = w_en[0][0];
  assign o_bank0_en_p1   = w_en[0][1];
  assign o_bank1_en_p0   = w_en[1][0];
  assign o_bank1_en_p1   = w_en[1][1];
  assign o_bank0_addr_p0 = w_addr[0][0];
  assign o_bank0_addr_p1 = w_addr[0][1];
  assign o_bank1_addr_p0 = w_addr[1][0];
  assign o_bank1_addr_p1 = w_addr[1][1];

endmodule

`default_nettype wire

// File: tb/tb_ib_lut_bank_rd_sched.sv
// ============================================================================
// Module  : tb_ib_lut_bank_rd_sched
// Brief   : Directed self-checking bench for ib_lut_bank_rd_sched with a
//           one-cycle-latency bank memory model (bank0[p]=p, bank1[p]=~p).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ib_lut_bank_rd_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req_valid, req_ready;
  logic [2:0] pa, pb, pc, pd;
  logic       ba, bb, bc, bd;
  logic       b0e0, b0e1, b1e0, b1e1;
  logic [2:0] b0a0, b0a1, b1a0, b1a1;
  logic [2:0] b0d0 = '0, b0d1 = '0, b1d0 = '0, b1d1 = '0;
  logic       rsp_valid, rsp_ready;
  logic [2:0] ra, rb, rc, rd;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  // Bank memory model: registered read, one cycle after enable.
  always @(posedge clk) begin
    if (b0e0) b0d0 <= b0a0;
    if (b0e1) b0d1 <= b0a1;
    if (b1e0) b1d0 <= ~b1a0;
    if (b1e1) b1d1 <= ~b1a1;
  end

  ib_lut_bank_rd_sched #(.ADDR_BW(3), .DATA_BW(3)) dut (
    .i_sys_clk(clk), .i_rstn(rstn),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_page_addr_a(pa), .i_page_addr_b(pb), .i_page_addr_c(pc), .i_page_addr_d(pd),
    .i_bank_addr_a(ba), .i_bank_addr_b(bb), .i_bank_addr_c(bc), .i_bank_addr_d(bd),
    .o_bank0_en_p0(b0e0), .o_bank0_en_p1(b0e1), .o_bank1_en_p0(b1e0), .o_bank1_en_p1(b1e1),
    .o_bank0_addr_p0(b0a0), .o_bank0_addr_p1(b0a1), .o_bank1_addr_p0(b1a0), .o_bank1_addr_p1(b1a1),
    .i_bank0_dout_p0(b0d0), .i_bank0_dout_p1(b0d1), .i_bank1_dout_p0(b1d0), .i_bank1_dout_p1(b1d1),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data_a(ra), .o_rsp_data_b(rb), .o_rsp_data_c(rc), .o_rsp_data_d(rd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".req_ready"}, {15'd0, req_ready}, 16'd1);
    chk({tag, ".rsp_valid"}, {15'd0, rsp_valid}, 16'd0);
    chk({tag, ".bank_en"}, {12'd0, b0e0, b0e1, b1e0, b1e1}, 16'd0);
  endtask

  task automatic chk_data(input string tag, input logic [2:0] ea, input logic [2:0] eb,
                          input logic [2:0] ec, input logic [2:0] ed);
    chk({tag, ".data"}, {4'd0, ra, rb, rc, rd}, {4'd0, ea, eb, ec, ed});
  endtask

  // Present a request and step through the accepting edge.
  task automatic send(input string tag,
                      input logic a_b, input logic [2:0] a_p, input logic b_b, input logic [2:0] b_p,
                      input logic c_b, input logic [2:0] c_p, input logic d_b, input logic [2:0] d_p);
    ba = a_b; pa = a_p; bb = b_b; pb = b_p; bc = c_b; pc = c_p; bd = d_b; pd = d_p;
    req_valid = 1'b1;
    chk({tag, ".ready_before_fire"}, {15'd0, req_ready}, 16'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Count edges after the fire edge until rsp_valid rises (bounded).
  task automatic wait_rsp(input string tag, output int cnt);
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    if (!rsp_valid) chk({tag, ".rsp_timeout"}, 16'd0, 16'd1);
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    pa = '0; pb = '0; pc = '0; pd = '0; ba = 1'b0; bb = 1'b0; bc = 1'b0; bd = 1'b0;

    // T1: reset
    tick(); tick();
    chk_idle("T1");
    chk_data("T1", 3'd0, 3'd0, 3'd0, 3'd0);
    rstn = 1'b1;
    tick();

    // T2: 2/2 split, single issue cycle
    send("T2", 1'b0, 3'd1, 1'b1, 3'd2, 1'b0, 3'd3, 1'b1, 3'd4);
    chk("T2.en", {12'd0, b0e0, b0e1, b1e0, b1e1}, 16'hF);
    chk("T2.addr", {4'd0, b0a0, b0a1, b1a0, b1a1}, {4'd0, 3'd1, 3'd3, 3'd2, 3'd4});
    wait_rsp("T2", n);
    chk("T2.latency", n[15:0], 16'd2);
    chk_data("T2", 3'd1, 3'd5, 3'd3, 3'd3);
    tick();
    chk_idle("T2.after");

    // T3: 4/0 split, A,B then C,D
    send("T3", 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 3'd3);
    chk("T3.issue1", {4'd0, b0e0, b0e1, b1e0, b1e1, b0a0, b0a1}, {4'd0, 4'b1100, 3'd0, 3'd1});
    tick();
    chk("T3.issue2", {4'd0, b0e0, b0e1, b1e0, b1e1, b0a0, b0a1}, {4'd0, 4'b1100, 3'd2, 3'd3});
    wait_rsp("T3", n);
    chk("T3.latency", n[15:0], 16'd2);
    chk_data("T3", 3'd0, 3'd1, 3'd2, 3'd3);
    tick();

    // T4: four identical addresses on bank1
    send("T4", 1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 3'd6);
    wait_rsp("T4", n);
`ifdef IB_RD_ADDR_MERGE_EN
    chk("T4.latency_merge", n[15:0], 16'd2);
`else
    chk("T4.latency_nomerge", n[15:0], 16'd3);
`endif
    chk_data("T4", 3'd1, 3'd1, 3'd1, 3'd1);
    tick();

    // T5: back-pressure on the response
    rsp_ready = 1'b0;
    send("T5", 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 3'd3, 1'b0, 3'd5);
    wait_rsp("T5", n);
    for (int c = 0; c < 5; c++) begin
      chk("T5.hold_valid", {15'd0, rsp_valid}, 16'd1);
      chk("T5.hold_ready", {15'd0, req_ready}, 16'd0);
      chk("T5.hold_en", {12'd0, b0e0, b0e1, b1e0, b1e1}, 16'd0);
      chk_data("T5.hold", 3'd7, 3'd7, 3'd4, 3'd5);
      tick();
    end
    rsp_ready = 1'b1;
    chk("T5.valid_cycle6", {15'd0, rsp_valid}, 16'd1);
    tick();
    chk_idle("T5.release");

    // T6: reset during second issue cycle of a 4/0 request
    send("T6", 1'b0, 3'd4, 1'b0, 3'd5, 1'b0, 3'd6, 1'b0, 3'd7);
    tick();
    rstn = 1'b0;
    tick();
    chk_idle("T6.reset");
    chk_data("T6.reset", 3'd0, 3'd0, 3'd0, 3'd0);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("T6.no_rsp", {15'd0, rsp_valid}, 16'd0);
    end
    send("T6b", 1'b1, 3'd1, 1'b0, 3'd6, 1'b1, 3'd7, 1'b0, 3'd2);
    wait_rsp("T6b", n);
    chk("T6b.latency", n[15:0], 16'd2);
    chk_data("T6b", 3'd6, 3'd6, 3'd0, 3'd2);
    tick();
    chk_idle("T6b.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
